// File: rtl/grant_decoder_if.sv
// Handshake and output bundle for grant_decoder: producer pushes {index, hold},
// consumer side exposes the timed one-hot strobe plus status.
interface grant_decoder_if #(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_index;
  logic [HOLD_W-1:0] in_hold;
  logic              enable;
  logic [7:0]        out_onehot;
  logic              out_valid;
  logic              busy;
  logic [CW-1:0]     count;

  modport master (
    output in_valid, in_index, in_hold, enable,
    input  in_ready, out_onehot, out_valid, busy, count
  );

  modport slave (
    input  in_valid, in_index, in_hold, enable,
    output in_ready, out_onehot, out_valid, busy, count
  );
endinterface

// File: rtl/grant_decoder.sv
// Buffered, timed 3-to-8 decoder: queues {index, hold} entries and drives each
// decoded line for max(hold,1) enabled cycles, back-to-back with no gaps.
module grant_decoder #(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  grant_decoder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic [2:0]        index;
    logic [HOLD_W-1:0] hold;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  state_t            state;
  logic [2:0]        cur_index;
  logic [HOLD_W-1:0] hold_cnt;

  logic   push, pop, empty, last;
  entry_t head;

  assign bus.in_ready = (count_q != CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign empty        = (count_q == '0);
  assign last         = (hold_cnt == HOLD_W'(1));
  assign head         = mem[rd_ptr];
  // A pop happens on the IDLE->ACTIVE start or on the final cycle of an entry.
  assign pop          = bus.enable && !empty && (state == IDLE || last);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{index: bus.in_index, hold: bus.in_hold};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_index <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          state     <= ACTIVE;
          cur_index <= head.index;
          hold_cnt  <= (head.hold == '0) ? HOLD_W'(1) : head.hold;
        end
        ACTIVE: if (bus.enable) begin
          if (!last) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else if (!empty) begin
            cur_index <= head.index;
            hold_cnt  <= (head.hold == '0) ? HOLD_W'(1) : head.hold;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == ACTIVE);
  assign bus.out_valid = bus.busy && bus.enable;
  assign bus.count     = count_q;

  for (genvar i = 0; i < 8; i++) begin : g_line
    assign bus.out_onehot[i] = bus.out_valid && (cur_index == 3'(i));
  end
endmodule

// File: tb/tb_grant_decoder.sv
// Self-checking bench for grant_decoder: constant vector tables, hand sequences
// and randomized traffic against a queue-based reference model.
module tb_grant_decoder;
  localparam int DEPTH  = 4;
  localparam int HOLD_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  grant_decoder_if #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) bus ();
  grant_decoder #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int idx;
    int hold;
  } ent_t;

  typedef struct {
    bit       v;
    int       idx;
    int       hold;
    bit       en;
    bit [7:0] oh;
    bit       busy;
    int       cnt;
    bit       rdy;
  } vec_t;

  int errors = 0;
  int checks = 0;

  ent_t q[$];
  bit   m_act;
  int   m_rem, m_idx;

  bit [7:0] watch;
  int       watch_hits;
  bit       rec;
  bit [7:0] seen[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_act = 0;
    m_rem = 0;
    m_idx = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model and DUT.
  task automatic cyc(input bit v, input int idx, input int h, input bit en);
    bit [7:0] exp_oh;
    bit       acc;
    ent_t     e;
    bus.in_valid = v;
    bus.in_index = idx[2:0];
    bus.in_hold  = h[HOLD_W-1:0];
    bus.enable   = en;
    #1;
    exp_oh = (m_act && en) ? (8'h01 << m_idx) : 8'h00;
    chk("model_onehot", int'(bus.out_onehot), int'(exp_oh));
    chk("model_valid",  int'(bus.out_valid),  int'(m_act && en));
    chk("model_busy",   int'(bus.busy),       int'(m_act));
    chk("model_count",  int'(bus.count),      q.size());
    chk("model_ready",  int'(bus.in_ready),   int'(q.size() < DEPTH));
    chk("onehot_form",  int'($countones(bus.out_onehot) <= 1), 1);
    if (bus.out_onehot == watch && watch != 0) watch_hits++;
    if (rec && bus.out_onehot != 0) seen.push_back(bus.out_onehot);

    acc = v && (q.size() < DEPTH);
    if (en) begin
      if (!m_act || m_rem == 1) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_act = 1;
          m_idx = e.idx;
          m_rem = (e.hold == 0) ? 1 : e.hold;
        end else begin
          m_act = 0;
        end
      end else begin
        m_rem--;
      end
    end
    if (acc) q.push_back('{idx: idx & 7, hold: h & ((1 << HOLD_W) - 1)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_index = 0; bus.in_hold = 0; bus.enable = 0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    watch = 0; watch_hits = 0; rec = 0;
    do_reset();

    // Single entry {5,3} then three back-to-back {0,1},{7,0},{3,2}.
    tbl.push_back('{1,5,3,1, 8'h00,0,0,1});
    tbl.push_back('{0,0,0,1, 8'h00,0,1,1});
    tbl.push_back('{0,0,0,1, 8'h20,1,0,1});
    tbl.push_back('{0,0,0,1, 8'h20,1,0,1});
    tbl.push_back('{0,0,0,1, 8'h20,1,0,1});
    tbl.push_back('{0,0,0,1, 8'h00,0,0,1});
    tbl.push_back('{1,0,1,1, 8'h00,0,0,1});
    tbl.push_back('{1,7,0,1, 8'h00,0,1,1});
    tbl.push_back('{1,3,2,1, 8'h01,1,1,1});
    tbl.push_back('{0,0,0,1, 8'h80,1,1,1});
    tbl.push_back('{0,0,0,1, 8'h08,1,0,1});
    tbl.push_back('{0,0,0,1, 8'h08,1,0,1});
    tbl.push_back('{0,0,0,1, 8'h00,0,0,1});
    for (int i = 0; i < tbl.size(); i++) begin
      bus.in_valid = tbl[i].v;
      bus.in_index = tbl[i].idx[2:0];
      bus.in_hold  = tbl[i].hold[HOLD_W-1:0];
      bus.enable   = tbl[i].en;
      #1;
      chk("tbl_onehot", int'(bus.out_onehot), int'(tbl[i].oh));
      chk("tbl_valid",  int'(bus.out_valid),  int'(tbl[i].oh != 0));
      chk("tbl_busy",   int'(bus.busy),       int'(tbl[i].busy));
      chk("tbl_count",  int'(bus.count),      tbl[i].cnt);
      chk("tbl_ready",  int'(bus.in_ready),   int'(tbl[i].rdy));
      cyc(tbl[i].v, tbl[i].idx, tbl[i].hold, tbl[i].en);
    end

    // Fill while paused, refuse a fifth entry, then drain in order.
    for (int i = 1; i <= 4; i++) cyc(1, i, 1, 0);
    chk("fill_count", int'(bus.count), 4);
    chk("fill_ready", int'(bus.in_ready), 0);
    cyc(1, 6, 1, 0);
    chk("fifth_ignored", int'(bus.count), 4);
    rec = 1; seen.delete();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    rec = 0;
    chk("drain_len", seen.size(), 4);
    if (seen.size() == 4) begin
      chk("drain_0", int'(seen[0]), 'h02);
      chk("drain_1", int'(seen[1]), 'h04);
      chk("drain_2", int'(seen[2]), 'h08);
      chk("drain_3", int'(seen[3]), 'h10);
    end

    // Pause for two cycles during the second active cycle of {2,4}.
    watch = 8'h04; watch_hits = 0;
    cyc(1, 2, 4, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("pause_busy", int'(bus.busy), 1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    chk("pause_hits", watch_hits, 4);

    // All-ones hold gives 15 active cycles.
    watch = 8'h02; watch_hits = 0;
    cyc(1, 1, 15, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1);
    chk("maxhold_hits", watch_hits, 15);
    watch = 0;

    // Randomized traffic crossing pointer wrap with simultaneous push/pop.
    for (int i = 0; i < 300; i++)
      cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 1);

    // Reset mid-entry with three entries still queued.
    for (int i = 0; i < 4; i++) cyc(1, 4 + i, 3, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("pre_reset_count", int'(bus.count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_onehot", int'(bus.out_onehot), 0);
    chk("rst_valid",  int'(bus.out_valid), 0);
    chk("rst_busy",   int'(bus.busy), 0);
    chk("rst_count",  int'(bus.count), 0);
    chk("rst_ready",  int'(bus.in_ready), 1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
